ser40x13: RTL and testbench

//  Transmit-side counterpart of des13x40: packs a stream of 40-bit words into a continuous
//  13-bit-per-clock output stream. Bits are carried across word boundaries without padding:
//  13 input words produce exactly 40 output words (520 bits).

---
 rtl/ser40x13_pkg.sv | 15 +
 rtl/ser40x13_bitbuf.sv | 29 ++
 rtl/ser40x13.sv | 60 ++++++
 tb/tb_ser40x13.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ser40x13_pkg.sv
// rtl/ser40x13_pkg.sv - shared widths for the 40->13 serializer and its 13->40 counterpart
package ser40x13_pkg;

    localparam int W_IN  = 40;
    localparam int W_OUT = 13;
    localparam int BUF_W = W_IN + W_OUT - 1;
    localparam int CNT_W = 6;

    // Left-align the word in the buffer, then drop it below the rem bits still pending.
    function automatic logic [BUF_W-1:0] place_word(input logic [W_IN-1:0]  word,
                                                    input logic [CNT_W-1:0] rem);
        return {word, {(BUF_W-W_IN){1'b0}}} >> rem;
    endfunction

endpackage

// File: rtl/ser40x13_bitbuf.sv
// rtl/ser40x13_bitbuf.sv - pending-bit buffer with 13-bit drain and variable-offset word insert
module ser40x13_bitbuf
    import ser40x13_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             emit,
    input  logic             load,
    input  logic [CNT_W-1:0] rem,
    input  logic [W_IN-1:0]  din,
    output logic [BUF_W-1:0] bits
);

    logic [BUF_W-1:0] kept;

    // Bits below the pending count are always zero, so the insert can simply OR in.
    assign kept = emit ? (bits << W_OUT) : bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (load) begin
            bits <= kept | place_word(din, rem);
        end else begin
            bits <= kept;
        end
    end

endmodule

// File: rtl/ser40x13.sv
// rtl/ser40x13.sv - packs 40-bit words into a continuous MSB-first 13-bit stream
module ser40x13
    import ser40x13_pkg::*;
(
    input  logic             Cin,
    input  logic             Rn,
    input  logic [W_IN-1:0]  Din,
    input  logic             Vin,
    output logic             RDY,
    output logic [W_OUT-1:0] Dout,
    output logic             DV,
    output logic             UF
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rem;
    logic             emit;
    logic             load;
    logic             started;
    logic [BUF_W-1:0] bits;

    assign emit = (cnt >= CNT_W'(W_OUT));
    assign rem  = emit ? (cnt - CNT_W'(W_OUT)) : cnt;
    assign RDY  = (rem <= CNT_W'(W_OUT - 1));
    assign load = Vin && RDY;

    ser40x13_bitbuf u_bitbuf (
        .clk   (Cin),
        .rst_n (Rn),
        .emit  (emit),
        .load  (load),
        .rem   (rem),
        .din   (Din),
        .bits  (bits)
    );

    always_ff @(posedge Cin or negedge Rn) begin
        if (!Rn) begin
            cnt     <= '0;
            Dout    <= '0;
            DV      <= 1'b0;
            UF      <= 1'b0;
            started <= 1'b0;
        end else begin
            cnt <= load ? (rem + CNT_W'(W_IN)) : rem;
            if (emit) begin
                Dout    <= bits[BUF_W-1 -: W_OUT];
                DV      <= 1'b1;
                started <= 1'b1;
            end else begin
                DV <= 1'b0;
                // Once the stream has begun, any idle cycle is a break in the link.
                if (started) begin
                    UF <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ser40x13.sv
// tb/tb_ser40x13.sv - randomized bit-queue reference check of ser40x13 plus directed literal cases
module tb_ser40x13;

    logic        Cin = 1'b0;
    logic        Rn  = 1'b0;
    logic [39:0] Din = '0;
    logic        Vin = 1'b0;
    logic        RDY;
    logic [12:0] Dout;
    logic        DV;
    logic        UF;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    bit          q[$];
    logic [12:0] m_dout = '0;
    logic        m_dv = 1'b0;
    logic        m_uf = 1'b0;
    bit          m_started = 1'b0;
    logic [12:0] seen[$];

    ser40x13 dut (
        .Cin  (Cin),
        .Rn   (Rn),
        .Din  (Din),
        .Vin  (Vin),
        .RDY  (RDY),
        .Dout (Dout),
        .DV   (DV),
        .UF   (UF)
    );

    always #5 Cin = ~Cin;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_rdy();
        int sz;
        sz = q.size();
        if (sz >= 13) sz = sz - 13;
        return (sz <= 12);
    endfunction

    // Reference: a plain FIFO of bits; 13 leave per cycle whenever available.
    always @(posedge Cin or negedge Rn) begin
        if (!Rn) begin
            q.delete();
            m_dout    = '0;
            m_dv      = 1'b0;
            m_uf      = 1'b0;
            m_started = 1'b0;
        end else begin
            if (q.size() >= 13) begin
                logic [12:0] v;
                v = '0;
                for (int b = 0; b < 13; b++) v = {v[11:0], q.pop_front()};
                m_dout    = v;
                m_dv      = 1'b1;
                m_started = 1'b1;
            end else begin
                m_dv = 1'b0;
                if (m_started) m_uf = 1'b1;
            end
            if (Vin && q.size() <= 12) begin
                for (int b = 39; b >= 0; b--) q.push_back(Din[b]);
            end
        end
    end

    always @(negedge Cin) begin
        if (chk_en) begin
            check("dout", {27'd0, Dout}, {27'd0, m_dout});
            check("dv", {39'd0, DV}, {39'd0, m_dv});
            check("uf", {39'd0, UF}, {39'd0, m_uf});
            check("rdy", {39'd0, RDY}, {39'd0, exp_rdy()});
            if (DV) seen.push_back(Dout);
        end
    end

    task automatic do_reset();
        @(negedge Cin);
        #1;
        Rn  = 1'b0;
        Vin = 1'b0;
        repeat (2) @(negedge Cin);
        #2;
        Rn = 1'b1;
        @(negedge Cin);
        #1;
        seen.delete();
    endtask

    task automatic send(input logic [39:0] w);
        int n;
        @(negedge Cin);
        #1;
        Din = w;
        Vin = 1'b1;
        n = 0;
        while (!RDY && n < 100) begin
            @(negedge Cin);
            #1;
            n++;
        end
        check("send_bound", {39'd0, (n < 100)}, 40'd1);
        @(posedge Cin);
        #1;
        Vin = 1'b0;
    endtask

    initial begin
        logic [12:0] exp2[4];
        int loads;
        int dvc;

        Rn = 1'b0;
        @(negedge Cin);
        chk_en = 1'b1;
        repeat (3) @(negedge Cin);
        #1;
        check("rst_dout", {27'd0, Dout}, 40'd0);
        check("rst_dv", {39'd0, DV}, 40'd0);
        check("rst_uf", {39'd0, UF}, 40'd0);
        check("rst_rdy", {39'd0, RDY}, 40'd1);
        #2;
        Rn = 1'b1;
        repeat (2) begin
            @(negedge Cin);
            #1;
            check("rst_release_dv", {39'd0, DV}, 40'd0);
        end

        // Bit order across a word boundary
        do_reset();
        send(40'h80_0000_0001);
        send(40'h00_0000_0000);
        repeat (8) @(negedge Cin);
        #1;
        exp2[0] = 13'h1000;
        exp2[1] = 13'h0000;
        exp2[2] = 13'h0000;
        exp2[3] = 13'h1000;
        check("order_count", 40'(seen.size()), 40'd6);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) check("order_word", {27'd0, seen[i]}, {27'd0, exp2[i]});
        end

        // Single all-ones word then starvation
        do_reset();
        send(40'hFF_FFFF_FFFF);
        repeat (8) @(negedge Cin);
        #1;
        check("uf_count", 40'(seen.size()), 40'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size()) check("uf_word", {27'd0, seen[i]}, 40'h1FFF);
        end
        check("uf_dv", {39'd0, DV}, 40'd0);
        check("uf_flag", {39'd0, UF}, 40'd1);
        check("uf_rdy", {39'd0, RDY}, 40'd1);

        // Continuous source: 13 loads in the first 40 cycles, 40 back-to-back outputs
        do_reset();
        loads = 0;
        dvc   = 0;
        for (int i = 0; i <= 41; i++) begin
            @(negedge Cin);
            #1;
            if (DV) dvc++;
            if (i < 41) begin
                Vin = 1'b1;
                Din = {8'($urandom), 32'($urandom)};
                if (i < 40 && RDY) loads++;
            end else begin
                Vin = 1'b0;
            end
        end
        check("thr_loads", 40'(loads), 40'd13);
        check("thr_dv", 40'(dvc), 40'd40);
        check("thr_uf", {39'd0, UF}, 40'd0);

        // Randomized traffic; Din churns even while stalled, one reset mid-stream
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge Cin);
                #1;
                Rn = 1'b0;
                #1;
                check("mid_reset_dv", {39'd0, DV}, 40'd0);
                @(negedge Cin);
                #2;
                Rn = 1'b1;
            end
            @(negedge Cin);
            #1;
            Vin = ((i / 200) % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            Din = {8'($urandom), 32'($urandom)};
        end
        Vin = 1'b0;
        repeat (5) @(negedge Cin);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
